bht_resolve_table: RTL and testbench
====================================

Name: bht_resolve_table

Overview:
- Frontend branch history table that consumes the resolved-branch record produced by the execute-stage branch unit.
- Trains 2-bit saturating counters from resolved conditional branches and serves a single combinational taken/not-taken lookup to PC generation.
- Storage is an unreset flop/SRAM-style array that is cleared by an index-sweep FSM after reset and on predictor flush.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; uses VLEN and RVC.
- bp_resolve_t, logic, resolved-branch type with fields valid, pc, target_address, is_taken, is_mispredict, cf_type, metadata.
- NR_ENTRIES, 128, number of table rows; power of two, at least 2.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_bp_i  input  1  clear all predictor state.
- debug_mode_i  input  1  core is in debug mode; training is suppressed.
- vpc_i  input  VLEN  lookup PC.
- resolved_branch_i  input  bp_resolve_t  resolution from the branch unit.
- predict_valid_o  output  1  lookup hit on a trained row.
- predict_taken_o  output  1  predicted direction.
- busy_o  output  1  sweep in progress.

Behaviour:
Clock and reset:
- Single clock clk_i; reset rst_ni is asynchronous and active-low.

Indexing:
- LSB = 1 if CVA6Cfg.RVC, else 2.
- idx(pc) = pc[LSB +: log2(NR_ENTRIES)]. No tag; aliasing is accepted.
- Each row holds a valid bit and a 2-bit counter. Encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.

FSM:
- States: INIT, IDLE, FLUSH.
- Reset: state=INIT, sweep index=0, update stage register valid=0.
- INIT/FLUSH: each cycle write row[index] valid=0, counter=01, then index++. On index==NR_ENTRIES-1, go to IDLE. Sweep length is exactly NR_ENTRIES cycles.
- IDLE: on flush_bp_i, go to FLUSH with index=0.
- flush_bp_i in FLUSH restarts the sweep at index 0.
- flush_bp_i in INIT is ignored.
- busy_o = (state != IDLE). Reset value is 1.

Lookup (combinational, same cycle):
- predict_valid_o = (state==IDLE) && row[idx(vpc_i)].valid.
- predict_taken_o = predict_valid_o && row.counter[1].
- Both outputs are 0 during reset and sweep.

Update pipeline:
- Cycle t accept: resolved_branch_i.valid && cf_type==ariane_pkg::Branch && !debug_mode_i && state==IDLE && !flush_bp_i. On accept, register {pc index, is_taken} into stage 1.
- Other cf_types (JumpR, Return, NoCF, etc.) are ignored; they belong to the BTB and RAS.
- Cycle t+1: stage 1 does read-modify-write of row[idx] within that same cycle.
  - Row invalid: valid=1, counter = is_taken ? 10 : 01.
  - Row valid: saturating increment if taken, decrement if not. 11 holds on taken; 00 holds on not-taken.
- The new value is visible to lookups at cycle t+2. A lookup at t+1 returns the old value; there is no bypass.
- Back-to-back updates to the same row are correct because read and write happen in the same stage.
- A flush_bp_i asserted while stage 1 is valid drops the pending update; the sweep owns the array that cycle.
- Sweep writes take priority over any update.
- The update is applied regardless of is_mispredict; only is_taken trains the counter.
- Reset mid-operation: async clear of FSM and stage 1, then a full INIT sweep.

Test Plan:
- Reset, NR_ENTRIES=128 -> busy_o=1 for exactly 128 cycles then 0; predict_valid_o=0 throughout.
- After init, resolve Branch pc=0x80000010 taken at t -> lookup vpc=0x80000010: predict_valid_o=0 at t+1; valid=1, taken=1 (counter 10) at t+2.
- Four taken resolutions then one not-taken on the same pc, back-to-back -> counter 11 then 10; predict_taken_o=1 at the end. Two further not-taken -> counter 00, predict_taken_o=0.
- Resolutions with cf_type=JumpR, or debug_mode_i=1, or resolved_branch_i.valid=0 -> no row change; lookup stays valid=0.
- Train row, then flush_bp_i in the same cycle as a taken resolution -> update dropped; busy_o=1 for 128 cycles; lookup valid=0 afterward. A second flush at sweep index 50 -> sweep restarts at 0 and completes 128 cycles later.
- RVC=1: pc 0x100 and 0x100+2*128 alias to the same row. Train one taken -> the other reads valid=1, taken=1. RVC=0 maps 0x102 and 0x100 to the same row.

Source files
------------

// File: rtl/bht_resolve_table.sv
// bht_resolve_table: 2-bit saturating-counter branch history table trained from resolved branches.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_bp_i            clear all predictor state (restarts the sweep)
//   debug_mode_i          suppresses training while the core is in debug mode
//   vpc_i                 lookup PC for the combinational prediction
//   resolved_branch_i     resolution record from the execute-stage branch unit
//   predict_valid_o       lookup hit on a trained row
//   predict_taken_o       predicted direction
//   busy_o                clearing sweep in progress
package bht_resolve_pkg;
    typedef struct packed {
        int unsigned VLEN;
        bit          RVC;
    } cfg_t;
    localparam cfg_t cfg_default = '{VLEN: 64, RVC: 1'b1};
    typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_taken;
        logic        is_mispredict;
        cf_t         cf_type;
        logic [3:0]  metadata;
    } bp_resolve_t;
endpackage

module bht_resolve_table #(
    parameter bht_resolve_pkg::cfg_t CVA6Cfg    = bht_resolve_pkg::cfg_default,
    parameter type                   bp_resolve_t = bht_resolve_pkg::bp_resolve_t,
    parameter int unsigned           NR_ENTRIES = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_bp_i,
    input  logic                    debug_mode_i,
    input  logic [CVA6Cfg.VLEN-1:0] vpc_i,
    input  bp_resolve_t             resolved_branch_i,
    output logic                    predict_valid_o,
    output logic                    predict_taken_o,
    output logic                    busy_o
);
    localparam int unsigned IW  = $clog2(NR_ENTRIES);
    localparam int unsigned LSB = CVA6Cfg.RVC ? 1 : 2;
    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] sweep_idx_q, sweep_idx_d;
    logic [IW-1:0] upd_idx_q, upd_idx_d;
    logic          upd_valid_q, upd_valid_d;
    logic          upd_taken_q, upd_taken_d;
    logic          row_valid_q [NR_ENTRIES];
    logic [1:0]    row_cnt_q   [NR_ENTRIES];
    logic          idle, wr_en, wr_valid;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [1:0]    wr_cnt, old_cnt;
    logic          unused;

    assign unused          = ^{resolved_branch_i, vpc_i};
    assign idle            = state_q == IDLE;
    assign busy_o          = !idle;
    assign rd_idx          = vpc_i[LSB +: IW];
    assign predict_valid_o = idle && row_valid_q[rd_idx];
    assign predict_taken_o = predict_valid_o && row_cnt_q[rd_idx][1];

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q + IW'(1);
        if (idle) begin
            sweep_idx_d = '0;
            state_d     = flush_bp_i ? FLUSH : IDLE;
        end else if (state_q == FLUSH && flush_bp_i) begin
            sweep_idx_d = '0;
        end else if (sweep_idx_q == IW'(NR_ENTRIES - 1)) begin
            state_d = IDLE;
        end
        upd_valid_d = resolved_branch_i.valid && resolved_branch_i.cf_type == bht_resolve_pkg::Branch
                      && !debug_mode_i && idle && !flush_bp_i;
        upd_idx_d   = resolved_branch_i.pc[LSB +: IW];
        upd_taken_d = resolved_branch_i.is_taken;
    end

    // Single write port: the sweep owns the array whenever it runs; a flush
    // cycle drops the pending update.
    always_comb begin
        old_cnt  = row_cnt_q[upd_idx_q];
        wr_en    = !idle || (upd_valid_q && !flush_bp_i);
        wr_idx   = idle ? upd_idx_q : sweep_idx_q;
        wr_valid = idle;
        wr_cnt   = !idle ? 2'b01 :
                   !row_valid_q[upd_idx_q] ? {upd_taken_q, !upd_taken_q} :
                   upd_taken_q ? (old_cnt == 2'b11 ? 2'b11 : old_cnt + 2'd1) :
                                 (old_cnt == 2'b00 ? 2'b00 : old_cnt - 2'd1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    // Storage is deliberately unreset; the sweep initialises it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            row_valid_q[wr_idx] <= wr_valid;
            row_cnt_q[wr_idx]   <= wr_cnt;
        end
    end
endmodule

// File: tb/tb_bht_resolve_table.sv
// tb_bht_resolve_table: checks bht_resolve_table (RVC=1 and RVC=0 instances) against a table model.
module tb_bht_resolve_table;
    import bht_resolve_pkg::*;
    localparam int NR = 128;
    localparam cfg_t CFG_C = '{VLEN: 64, RVC: 1'b1};
    localparam cfg_t CFG_N = '{VLEN: 64, RVC: 1'b0};

    logic clk = 0, rst_ni = 0, flush = 0, dbg = 0;
    logic [63:0] vpc = '0;
    bp_resolve_t rb = '0;
    logic pv_a, pt_a, busy_a, pv_b, pt_b, busy_b;
    int checks = 0, errors = 0;

    bit          m_v [2][NR];
    int          m_c [2][NR];
    int          m_busy;
    bit          m_flushing, m_pend, m_ptaken;
    logic [63:0] m_ppc;

    always #5 clk = ~clk;

    bht_resolve_table #(.CVA6Cfg(CFG_C), .NR_ENTRIES(NR)) dut_c (
        .clk_i(clk), .rst_ni(rst_ni), .flush_bp_i(flush), .debug_mode_i(dbg), .vpc_i(vpc),
        .resolved_branch_i(rb), .predict_valid_o(pv_a), .predict_taken_o(pt_a), .busy_o(busy_a));
    bht_resolve_table #(.CVA6Cfg(CFG_N), .NR_ENTRIES(NR)) dut_n (
        .clk_i(clk), .rst_ni(rst_ni), .flush_bp_i(flush), .debug_mode_i(dbg), .vpc_i(vpc),
        .resolved_branch_i(rb), .predict_valid_o(pv_b), .predict_taken_o(pt_b), .busy_o(busy_b));

    function automatic int idx(int k, logic [63:0] pc);
        return int'((pc >> (k == 0 ? 1 : 2)) % 128);
    endfunction
    function automatic bit exp_v(int k, logic [63:0] pc);
        return m_busy == 0 && m_v[k][idx(k, pc)];
    endfunction
    function automatic bit exp_t(int k, logic [63:0] pc);
        return exp_v(k, pc) && m_c[k][idx(k, pc)] >= 2;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) for (int i = 0; i < NR; i++) m_v[k][i] = 0;
    endtask

    // advance DUTs and model by one clock using currently driven inputs
    task automatic tick();
        bit idle = (m_busy == 0);
        if (idle && m_pend && !flush)
            for (int k = 0; k < 2; k++) begin
                int i = idx(k, m_ppc);
                if (!m_v[k][i]) begin m_v[k][i] = 1; m_c[k][i] = m_ptaken ? 2 : 1; end
                else m_c[k][i] = m_ptaken ? (m_c[k][i] < 3 ? m_c[k][i] + 1 : 3)
                                          : (m_c[k][i] > 0 ? m_c[k][i] - 1 : 0);
            end
        if (!idle) m_busy = (flush && m_flushing) ? NR : m_busy - 1;
        else if (flush) begin m_busy = NR; m_flushing = 1; m_clear(); end
        m_pend   = idle && rb.valid && rb.cf_type == Branch && !dbg && !flush;
        m_ppc    = rb.pc;
        m_ptaken = rb.is_taken;
        @(posedge clk); #1;
    endtask

    task automatic set_br(logic [63:0] pc, logic taken, cf_t cf, logic v);
        rb = '0; rb.valid = v; rb.pc = pc; rb.is_taken = taken; rb.cf_type = cf;
        rb.is_mispredict = 1'b1; rb.target_address = pc + 64'h40;
    endtask

    task automatic test_reset();
        int n = 0;
        rst_ni = 0; flush = 0; dbg = 0; rb = '0;
        m_pend = 0; m_flushing = 0; m_busy = NR; m_clear();
        #1;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
        checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b expected 0", pv_a); end
        repeat (2) @(posedge clk);
        #1; rst_ni = 1;
        while (busy_a === 1'b1 && n < 300) begin
            vpc = 64'($urandom);
            #1;
            if (pv_a !== 1'b0 || pt_a !== 1'b0) begin errors++; $display("FAIL init_pv: got %b%b expected 00 at cycle %0d", pv_a, pt_a, n); end
            tick(); n++;
        end
        checks++; if (n != NR) begin errors++; $display("FAIL init_len: got %0d expected %0d", n, NR); end
        checks++; if (busy_a !== 1'b0 || m_busy != 0) begin errors++; $display("FAIL init_done: got busy %b expected 0", busy_a); end
    endtask

    task automatic test_train_latency();
        set_br(64'h80000010, 1, Branch, 1); vpc = 64'h80000010; #1;
        checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL lat_t: got %b expected 0", pv_a); end
        tick(); rb = '0; #1;
        checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL lat_t1: got %b expected 0", pv_a); end
        tick();
        checks++; if (pv_a !== 1'b1 || pt_a !== 1'b1) begin errors++; $display("FAIL lat_t2: got %b%b expected 11", pv_a, pt_a); end
    endtask

    task automatic test_saturation();
        vpc = 64'h80000100;
        repeat (4) begin set_br(vpc, 1, Branch, 1); tick(); end
        set_br(vpc, 0, Branch, 1); tick();
        rb = '0; tick();
        checks++; if (pv_a !== 1'b1 || pt_a !== 1'b1) begin errors++; $display("FAIL sat_hi: got %b%b expected 11", pv_a, pt_a); end
        repeat (2) begin set_br(vpc, 0, Branch, 1); tick(); end
        rb = '0; tick();
        checks++; if (pv_a !== 1'b1 || pt_a !== 1'b0) begin errors++; $display("FAIL sat_down: got %b%b expected 10", pv_a, pt_a); end
        set_br(vpc, 1, Branch, 1); tick(); rb = '0; tick();
        checks++; if (pt_a !== 1'b0 || pt_a !== exp_t(0, vpc)) begin errors++; $display("FAIL sat_lo: got %b expected 0", pt_a); end
    endtask

    task automatic test_ignored();
        logic [63:0] pcs [3] = '{64'h80000044, 64'h80000046, 64'h80000048};
        for (int s = 0; s < 3; s++) begin
            set_br(pcs[s], 1, s == 0 ? JumpR : Branch, s != 2);
            dbg = (s == 1);
            tick(); rb = '0; dbg = 0;
            tick(); tick();
            vpc = pcs[s]; #1;
            checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL ignored_%0d: got %b expected 0", s, pv_a); end
        end
    endtask

    task automatic test_flush();
        int n = 0;
        vpc = 64'h80000060;
        set_br(vpc, 1, Branch, 1); tick(); rb = '0; tick();
        checks++; if (pv_a !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b expected 1", pv_a); end
        set_br(vpc, 1, Branch, 1); flush = 1; tick(); flush = 0; rb = '0;
        while (busy_a === 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (n != NR) begin errors++; $display("FAIL flush_len: got %0d expected %0d", n, NR); end
        checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", pv_a); end
        flush = 1; tick(); flush = 0;
        repeat (50) tick();
        flush = 1; tick(); flush = 0;
        n = 0;
        while (busy_a === 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (n != NR) begin errors++; $display("FAIL flush_restart: got %0d expected %0d", n, NR); end
    endtask

    task automatic test_alias();
        set_br(64'h102, 1, Branch, 1); tick(); rb = '0; tick();
        vpc = 64'h100; #1;
        checks++; if (pv_b !== 1'b1 || pt_b !== 1'b1) begin errors++; $display("FAIL alias_rvc0: got %b%b expected 11", pv_b, pt_b); end
        checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL alias_rvc1_sep: got %b expected 0", pv_a); end
        set_br(64'h100, 1, Branch, 1); tick(); rb = '0; tick();
        vpc = 64'h100 + 2 * NR; #1;
        checks++; if (pv_a !== 1'b1 || pt_a !== 1'b1) begin errors++; $display("FAIL alias_rvc1: got %b%b expected 11", pv_a, pt_a); end
    endtask

    task automatic test_random();
        logic [63:0] pool [8];
        for (int i = 0; i < 8; i++) pool[i] = 64'h80000000 + 64'($urandom_range(0, 63) << 1);
        for (int c = 0; c < 600; c++) begin
            rb.valid          = ($urandom % 4) != 0;
            rb.pc             = pool[$urandom % 8];
            rb.is_taken       = 1'($urandom);
            rb.is_mispredict  = 1'($urandom);
            rb.cf_type        = ($urandom % 10) < 6 ? Branch : cf_t'($urandom_range(0, 4));
            rb.target_address = {32'h0, $urandom};
            rb.metadata       = 4'($urandom);
            dbg   = ($urandom % 10) == 0;
            flush = ($urandom % 80) == 0;
            vpc   = pool[$urandom % 8];
            #1;
            checks++;
            if (pv_a !== exp_v(0, vpc) || pt_a !== exp_t(0, vpc) || busy_a !== (m_busy != 0)) begin
                errors++; $display("FAIL rand_rvc1 c%0d: got v%b t%b b%b expected v%b t%b b%b", c, pv_a, pt_a, busy_a, exp_v(0, vpc), exp_t(0, vpc), m_busy != 0);
            end
            checks++;
            if (pv_b !== exp_v(1, vpc) || pt_b !== exp_t(1, vpc) || busy_b !== (m_busy != 0)) begin
                errors++; $display("FAIL rand_rvc0 c%0d: got v%b t%b b%b expected v%b t%b b%b", c, pv_b, pt_b, busy_b, exp_v(1, vpc), exp_t(1, vpc), m_busy != 0);
            end
            tick();
        end
        rb = '0; dbg = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_train_latency();
        test_saturation();
        test_ignored();
        test_flush();
        test_alias();
        test_random();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
